rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Parametrised N-requester arbiter with registered one-hot grant.
- Selectable fixed-priority or round-robin policy, grant locking while the owner holds its request, and an optional hold timeout that forces rotation.
- Drives a grant-event counter onto the board LEDs.
- Shared-resource arbiter for sandbox designs, replacing the two-input fixed-priority grant logic.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, where req[0] is highest.
- MAX_HOLD, 0: max consecutive cycles one owner keeps the grant while others wait; 0 disables the timeout.
- LED_WIDTH, 8: width of the grant-event counter driven to leds.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i is requester i.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high when any gnt bit is set.
- gnt_idx  output  clog2(NUM_REQ)  binary index of the current owner; holds its last value when idle.
- leds  output  LED_WIDTH  count of new grant events; wraps modulo 2^LED_WIDTH.

Behaviour:
- Interface: one clock, `clock`; reset, `reset`, is asynchronous and active-high.
- Reset values:
  - gnt = 0, gnt_valid = 0, gnt_idx = 0, leds = 0.
  - Round-robin pointer ptr = 0, so req[0] has top priority.
  - hold counter = 0, state = IDLE.
  - Reset asserted mid-grant clears everything immediately; no grant survives reset.
- States:
  - IDLE: no owner.
  - OWNED: one owner.
- Winner selection (combinational, from req sampled this cycle):
  - RR_MODE=1: first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - RR_MODE=0: lowest set index.
- IDLE:
  - If req != 0, the winner is granted at the next edge and state becomes OWNED.
  - Grant latency is 1 cycle from req sampled high to gnt high.
  - If req == 0, stay IDLE with gnt = 0.
- OWNED, owner still requesting:
  - Grant holds while req[owner] = 1. It is locked: a higher-priority request never preempts, except by timeout.
- OWNED, owner drops request:
  - When req[owner] is sampled 0, the same edge re-arbitrates among the remaining req bits.
  - If a winner exists, its gnt is set with no idle bubble and state stays OWNED.
  - Otherwise gnt is cleared and state returns to IDLE.
- Timeout (MAX_HOLD > 0):
  - The hold counter increments each OWNED cycle in which the owner keeps the grant and another req bit is set.
  - Cycles with no other requester reset the counter to 0.
  - When the counter reaches MAX_HOLD, the next edge hands the grant to the winner among the other requesters; the owner's bit is excluded even though it is still high.
  - The pre-empted owner may win again later via normal rotation.
- Pointer update (RR_MODE=1 only):
  - On every new grant to index k, ptr <= (k+1) mod NUM_REQ.
  - ptr is unchanged while a grant is held.
  - RR_MODE=0 ignores ptr.
- Hold counter:
  - Resets to 0 on every new grant.
  - Width is clog2(MAX_HOLD+1).
- Grant events:
  - A new grant event is any edge where gnt changes to a non-zero value different from the previous gnt, including IDLE->OWNED and owner handover.
  - leds increments by 1 per event and wraps from all-ones to 0.
  - Holding a grant or returning to idle does not count.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx matches the set gnt bit whenever gnt_valid = 1.
  - No requester whose req bit is 0 is ever granted, except for the 1-cycle registered latency after it drops.

Test Plan:
1. Reset mid-grant: with gnt = 4'b0100, assert reset asynchronously between edges -> gnt = 0, leds = 0, gnt_valid = 0 without waiting for a clock edge; after release, req = 4'b1111 -> gnt = 4'b0001 one cycle later.
2. Round-robin rotation: NUM_REQ=4, RR_MODE=1, req held at 4'b1111 with each owner dropping and re-raising its bit after 2 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners; leds increments 1..5.
3. Fixed priority: RR_MODE=0, req = 4'b1010 -> gnt = 4'b0010; owner 1 drops -> gnt = 4'b1000 next edge; req[0] raised while 3 owns -> no preemption until req[3] drops.
4. Lock and timeout: MAX_HOLD=3, req[2] held continuously, req[0] raised -> gnt stays 4'b0100 for 3 cycles after req[0] rises, then gnt = 4'b0001; req[2] alone for 10 cycles -> no timeout.
5. Idle return and counter wrap: LED_WIDTH=8, generate 256 grant events -> leds wraps to 0; single request dropped -> gnt = 0 the next edge, gnt_idx holds its last value, leds unchanged.
6. Simultaneous events: owner drops exactly as two others rise in the same cycle with ptr = 2 and req = 4'b1001 -> gnt = 4'b1000, ptr becomes 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// N-requester arbiter with a registered one-hot grant and a selectable policy (round-robin or fixed priority).
// Grants lock while the owner keeps requesting; an optional hold timeout forces rotation; grant events are counted onto leds.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 0,
  parameter int LED_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic [LED_WIDTH-1:0]       leds
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next, gnt_idx_next, win_idx;
  logic [NUM_REQ-1:0] gnt_next, arb_mask;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic               win_found, arbitrate, new_event;
  logic               owner_req, others_req, timeout;

  assign gnt_valid  = |gnt;
  assign owner_req  = req[gnt_idx];
  assign others_req = |(req & ~gnt);
  assign timeout    = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

  // A timeout re-arbitrates with the current owner masked out even though it still requests.
  always_comb begin
    arbitrate = 1'b0;
    arb_mask  = req;
    if (state == IDLE) begin
      arbitrate = 1'b1;
    end else if (!owner_req) begin
      arbitrate = 1'b1;
    end else if (timeout && others_req) begin
      arbitrate = 1'b1;
      arb_mask  = req & ~gnt;
    end
  end

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (RR_MODE != 0) ? int'(ptr) + i : i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!win_found && arb_mask[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // gnt is one-hot or zero, so the new grant is an event exactly when its bit is not already set.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    gnt_idx_next = gnt_idx;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    new_event    = 1'b0;
    if (arbitrate) begin
      hold_next = '0;
      if (win_found) begin
        state_next        = OWNED;
        gnt_next          = '0;
        gnt_next[win_idx] = 1'b1;
        gnt_idx_next      = win_idx;
        new_event         = !gnt[win_idx];
        if (RR_MODE != 0)
          ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    end else if ((MAX_HOLD > 0) && others_req) begin
      hold_next = hold_cnt + 1'b1;
    end else begin
      hold_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      leds     <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      gnt_idx  <= gnt_idx_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
      if (new_event) leds <= leds + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a round-robin instance with hold timeout and a fixed-priority instance.
// Stimulus pushes hand-computed expectations; a monitor pops and compares them after each clock edge.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req_rr, req_fp, gnt_rr, gnt_fp;
  logic       valid_rr, valid_fp;
  logic [1:0] idx_rr, idx_fp;
  logic [7:0] leds_rr, leds_fp;

  int cyc         = 0;
  int n_compared  = 0;
  int n_failed    = 0;

  typedef struct {
    int         cycle;
    bit         fp;
    string      name;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic [7:0] leds;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  rr_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(3), .LED_WIDTH(8)) dut_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req_rr),
    .gnt       (gnt_rr),
    .gnt_valid (valid_rr),
    .gnt_idx   (idx_rr),
    .leds      (leds_rr)
  );

  rr_arbiter #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(0), .LED_WIDTH(8)) dut_fp (
    .clock     (clock),
    .reset     (reset),
    .req       (req_fp),
    .gnt       (gnt_fp),
    .gnt_valid (valid_fp),
    .gnt_idx   (idx_fp),
    .leds      (leds_fp)
  );

  task automatic checkOutput(input string name, input bit fp, input logic [3:0] g,
                             input logic [1:0] idx, input logic [7:0] l);
    logic [3:0] ag;
    logic       av;
    logic [1:0] ai;
    logic [7:0] al;
    ag = fp ? gnt_fp   : gnt_rr;
    av = fp ? valid_fp : valid_rr;
    ai = fp ? idx_fp   : idx_rr;
    al = fp ? leds_fp  : leds_rr;
    n_compared++;
    if (ag !== g || av !== (|g) || ai !== idx || al !== l) begin
      n_failed++;
      $display("[TB] FAIL %s: got gnt=%b valid=%b idx=%0d leds=%0d, want gnt=%b valid=%b idx=%0d leds=%0d",
               name, ag, av, ai, al, g, |g, idx, l);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r_rr, input logic [3:0] r_fp);
    @(negedge clock);
    req_rr = r_rr;
    req_fp = r_fp;
  endtask

  task automatic pushExpect(input string name, input bit fp, input logic [3:0] g,
                            input logic [1:0] idx, input logic [7:0] l);
    exp_t e;
    e.cycle = cyc + 1;
    e.fp    = fp;
    e.name  = name;
    e.gnt   = g;
    e.idx   = idx;
    e.leds  = l;
    sb_q.push_back(e);
  endtask

  task automatic stepRr(input logic [3:0] r, input string name, input logic [3:0] g,
                        input logic [1:0] idx, input logic [7:0] l);
    applyStimulus(r, 4'b0000);
    pushExpect(name, 1'b0, g, idx, l);
  endtask

  task automatic stepFp(input logic [3:0] r, input string name, input logic [3:0] g,
                        input logic [1:0] idx, input logic [7:0] l);
    applyStimulus(4'b0000, r);
    pushExpect(name, 1'b1, g, idx, l);
  endtask

  // Entries come due on the edge after they were pushed; compare a little after that edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      while (sb_q.size() > 0 && sb_q[0].cycle <= cyc) begin
        e = sb_q.pop_front();
        checkOutput(e.name, e.fp, e.gnt, e.idx, e.leds);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] r;
    reset  = 1'b1;
    req_rr = 4'b0000;
    req_fp = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_rr", 1'b0, 4'b0000, 2'd0, 8'd0);
    checkOutput("reset_fp", 1'b1, 4'b0000, 2'd0, 8'd0);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset while requester 2 owns the grant.
    stepRr(4'b0100, "t1_grant2", 4'b0100, 2'd2, 8'd1);
    pushExpect("t1_fp_idle", 1'b1, 4'b0000, 2'd0, 8'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t1_async_rr", 1'b0, 4'b0000, 2'd0, 8'd0);
    checkOutput("t1_async_fp", 1'b1, 4'b0000, 2'd0, 8'd0);
    @(negedge clock);
    reset  = 1'b0;
    req_rr = 4'b1111;
    pushExpect("t1_after_reset", 1'b0, 4'b0001, 2'd0, 8'd1);

    // Rotation 0,1,2,3,0 with each owner dropping for one cycle.
    stepRr(4'b1111, "t2_hold0", 4'b0001, 2'd0, 8'd1);
    stepRr(4'b1110, "t2_to1",   4'b0010, 2'd1, 8'd2);
    stepRr(4'b1111, "t2_hold1", 4'b0010, 2'd1, 8'd2);
    stepRr(4'b1101, "t2_to2",   4'b0100, 2'd2, 8'd3);
    stepRr(4'b1111, "t2_hold2", 4'b0100, 2'd2, 8'd3);
    stepRr(4'b1011, "t2_to3",   4'b1000, 2'd3, 8'd4);
    stepRr(4'b1111, "t2_hold3", 4'b1000, 2'd3, 8'd4);
    stepRr(4'b0111, "t2_to0",   4'b0001, 2'd0, 8'd5);
    stepRr(4'b0000, "t5_idle",  4'b0000, 2'd0, 8'd5);

    // Lock, no timeout when alone, timeout after MAX_HOLD contended cycles.
    stepRr(4'b0100, "t4_grant2", 4'b0100, 2'd2, 8'd6);
    for (int i = 0; i < 10; i++) stepRr(4'b0100, "t4_alone", 4'b0100, 2'd2, 8'd6);
    for (int i = 0; i < 3; i++) stepRr(4'b0101, "t4_locked", 4'b0100, 2'd2, 8'd6);
    stepRr(4'b0101, "t4_timeout",  4'b0001, 2'd0, 8'd7);
    stepRr(4'b0100, "t4_back2",    4'b0100, 2'd2, 8'd8);
    stepRr(4'b0000, "t5_idx_hold", 4'b0000, 2'd2, 8'd8);

    // Owner drops exactly as 0 and 3 rise with ptr at 2.
    stepRr(4'b0010, "t6_own1",  4'b0010, 2'd1, 8'd9);
    stepRr(4'b0010, "t6_hold1", 4'b0010, 2'd1, 8'd9);
    stepRr(4'b1001, "t6_simul", 4'b1000, 2'd3, 8'd10);
    stepRr(4'b1001, "t6_hold3", 4'b1000, 2'd3, 8'd10);
    stepRr(4'b0110, "t6_ptr0",  4'b0010, 2'd1, 8'd11);

    // Alternating single requesters give one event per cycle until leds wraps.
    for (int i = 0; i < 245; i++) begin
      r = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      stepRr(r, "t5_wrap", r, (i % 2 == 0) ? 2'd0 : 2'd1, 8'(12 + i));
    end
    stepRr(4'b0000, "t5_wrap_idle", 4'b0000, 2'd0, 8'd0);

    // Fixed priority instance.
    stepFp(4'b1010, "t3_prio",  4'b0010, 2'd1, 8'd1);
    stepFp(4'b1010, "t3_hold",  4'b0010, 2'd1, 8'd1);
    stepFp(4'b1000, "t3_to3",   4'b1000, 2'd3, 8'd2);
    for (int i = 0; i < 4; i++) stepFp(4'b1001, "t3_no_preempt", 4'b1000, 2'd3, 8'd2);
    stepFp(4'b0001, "t3_to0",    4'b0001, 2'd0, 8'd3);
    stepFp(4'b0110, "t3_lowest", 4'b0010, 2'd1, 8'd4);
    stepFp(4'b1001, "t3_fixed",  4'b0001, 2'd0, 8'd5);
    stepFp(4'b0000, "t3_idle",   4'b0000, 2'd0, 8'd5);

    repeat (4) @(posedge clock);
    #3;
    if (sb_q.size() != 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
